// File: rtl/pcs_rx_gearbox_pkg.sv
// Shared PCS constants: block geometry, sync header encodings and lane-count selection.
// Imported by the per-lane RX gearbox and its bench.
package pcs_rx_gearbox_pkg;

   localparam int PCS_HEAD_W  = 2;
   localparam int PCS_DATA_W  = 64;
   localparam int PCS_BLOCK_W = PCS_HEAD_W + PCS_DATA_W;

   typedef logic [PCS_HEAD_W-1:0] sync_head_t;

   localparam sync_head_t SYNC_DATA = 2'b01;
   localparam sync_head_t SYNC_CTRL = 2'b10;

   // 10G runs a single lane; the wider configurations stripe over four.
   localparam bit IS_10G = 1'b1;
   localparam int LANE_N = IS_10G ? 1 : 4;

endpackage

// File: rtl/pcs_rx_gearbox.sv
// Per-lane RX gearbox: packs DATA_W-bit SERDES words into HEAD_W+DATA_W blocks and
// drops one stream bit per slip request so block lock can hunt for alignment.
module pcs_rx_gearbox
   import pcs_rx_gearbox_pkg::*;
#(
   parameter int HEAD_W  = PCS_HEAD_W,
   parameter int DATA_W  = PCS_DATA_W,
   parameter int BLOCK_W = HEAD_W + DATA_W,
   parameter int FILL_W  = $clog2(2 * BLOCK_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              data_v_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              slip_i,
   output logic              valid_o,
   output logic [HEAD_W-1:0] head_o,
   output logic [DATA_W-1:0] data_o
);

   localparam int BUF_W = 2 * BLOCK_W;

   logic [BUF_W-1:0]  buf_q, buf_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              slip_pend_q, slip_pend_d;
   logic              valid_q, valid_d;
   logic [HEAD_W-1:0] head_q, head_d;
   logic [DATA_W-1:0] data_q, data_d;

   logic              head_drop;
   logic [BUF_W-1:0]  shifted;
   logic [BUF_W-1:0]  stream;
   logic [DATA_W-1:0] word;
   logic [FILL_W-1:0] eff_fill;
   logic [FILL_W-1:0] n;

   always_comb begin
      // With an empty buffer the slipped bit is the first bit of the incoming word.
      head_drop = slip_pend_q && (fill_q == '0);
      shifted   = slip_pend_q ? (buf_q >> 1) : buf_q;
      eff_fill  = head_drop ? '0 : (fill_q - FILL_W'(slip_pend_q));
      word      = head_drop ? (data_i >> 1) : data_i;
      stream    = shifted | (BUF_W'(word) << eff_fill);
      n         = eff_fill + (head_drop ? FILL_W'(DATA_W - 1) : FILL_W'(DATA_W));

      buf_d       = buf_q;
      fill_d      = fill_q;
      slip_pend_d = slip_pend_q | slip_i;
      valid_d     = 1'b0;
      head_d      = head_q;
      data_d      = data_q;

      if (data_v_i) begin
         slip_pend_d = slip_i;
         if (n >= FILL_W'(BLOCK_W)) begin
            valid_d = 1'b1;
            head_d  = stream[HEAD_W-1:0];
            data_d  = stream[BLOCK_W-1:HEAD_W];
            buf_d   = stream >> BLOCK_W;
            fill_d  = n - FILL_W'(BLOCK_W);
         end else begin
            buf_d  = stream;
            fill_d = n;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         buf_q       <= '0;
         fill_q      <= '0;
         slip_pend_q <= 1'b0;
         valid_q     <= 1'b0;
         head_q      <= '0;
         data_q      <= '0;
      end else begin
         buf_q       <= buf_d;
         fill_q      <= fill_d;
         slip_pend_q <= slip_pend_d;
         valid_q     <= valid_d;
         head_q      <= head_d;
         data_q      <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign head_o  = head_q;
   assign data_o  = data_q;

endmodule

// File: doc/pcs_rx_gearbox.md
Name: pcs_rx_gearbox

Overview:
Per-lane RX gearbox converting the raw DATA_W-bit SERDES word stream into HEAD_W+DATA_W (66b) blocks for pcs_rx. It is instantiated once per lane (LANE_N instances) ahead of pcs_rx, whose serdes_v_i, serdes_head_i and serdes_data_i it drives. It accepts the gearbox_slip request from pcs_rx's block-lock logic and realigns by discarding one bit per slip.

Parameters:
HEAD_W, 2, sync header width
DATA_W, 64, SERDES word width and block payload width
BLOCK_W, HEAD_W+DATA_W, block width (derived; do not override)
FILL_W, $clog2(2*BLOCK_W), width of the bit-fill counter (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
data_v_i  in  1  SERDES word valid
data_i  in  DATA_W  SERDES word; bit 0 is first on the wire
slip_i  in  1  slip request pulse from block lock (pcs_rx gearbox_slip_o)
valid_o  out  1  block valid (drives pcs_rx serdes_v_i)
head_o  out  HEAD_W  sync header; head_o[0] is first received bit
data_o  out  DATA_W  block payload; data_o[0] follows head_o[1] on the wire

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- State: bit buffer buf[2*BLOCK_W-1:0] (oldest bit at index 0), fill counter fill (0..BLOCK_W-1 after every update), slip_pend flag.
- Reset values: valid_o=0, head_o=0, data_o=0, fill=0, buf=0, slip_pend=0. Reset has priority over all other inputs and discards partial data; alignment restarts from the first data_v_i word after reset.
- slip_i=1 sets slip_pend. Multiple pulses while pending collapse into a single slip.
- Cycle with data_v_i=1:
  - s = slip_pend.
  - Append data_i above the s-bit-discarded buffer. The effective stream is buf[fill-1:s] followed by data_i; if fill==0 and s=1, data_i[0] is discarded.
  - n = fill - s + DATA_W, treating fill==0 with s=1 as n = DATA_W-1.
  - If n >= BLOCK_W: emit the lowest BLOCK_W bits (head_o = bits[1:0], data_o = bits[65:2]); valid_o=1 next cycle; fill <= n-BLOCK_W; remainder shifted to index 0.
  - Otherwise: valid_o=0; fill <= n.
  - slip_pend <= slip_i. A slip arriving this cycle is applied on the next valid word.
- Cycle with data_v_i=0: buf, fill and slip_pend are held (slip_i may still set slip_pend); valid_o=0. head_o and data_o hold their last value.
- Latency: a block is presented on the cycle after the word that completes it.
- Steady state without slip: period of 33 valid words yields 32 blocks. valid_o is low on the first word after fill reaches 0. fill sequence is 64, 62, 60 … 2, 0.
- Each slip delays block alignment by one bit. 66 slips return to the original alignment. Output of the slipped-word cycle already reflects the discard.
- head_o and data_o are don't-care when valid_o=0. The bench checks them only when valid_o=1.
- No header checking is done here; lock and slip decisions belong to pcs_rx.

Decomposition:
- Shared pcs package holds:
  - HEAD_W, DATA_W, BLOCK_W
  - sync header constants SYNC_DATA=2'b01, SYNC_CTRL=2'b10
  - LANE_N / IS_10G selection constants
- No sub-module. The buffer/shift logic is one always_ff plus a combinational shift-and-extract; the top level instantiates it in a per-lane generate loop.

Test Plan:
1. Reset, then 33 consecutive valid words carrying a serialized stream of 32 known blocks (headers 01/10) -> first valid_o on cycle after word 2; exactly 32 valid blocks matching in order; valid_o low once per 33 words; fill returns to 0.
2. Same stream with data_v_i deasserted for 1–3 random cycles -> identical block sequence; valid_o=0 during gaps; no bit lost or duplicated.
3. Stream pre-offset by 5 bits, slip_i pulsed after each invalid header -> after exactly 5 slips all following headers are 01/10 and payloads match. 66 slips on an aligned stream -> original alignment restored.
4. slip_i asserted before the first word after reset (fill=0) -> data_i[0] of word 1 discarded; first block = stream bits 1..66, emitted after word 2.
5. Reset asserted mid-stream with fill=38 and slip_pend=1 -> next cycle valid_o=0, fill=0, slip_pend=0; fresh aligned stream afterwards decodes correctly.
6. Two slip_i pulses while data_v_i=0, then one valid word -> exactly one bit discarded. slip_i coincident with a valid word -> applied on the following valid word, not the current one.
